// File: rtl/pio_gpio_pkg.sv
// Shared constants for the PIO/GPIO interrupt block.
//   ADDR_*  : register map of the 3-bit slave address space
//   EDGE_*  : encodings for the edge-capture mode parameter
package pio_gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchronizer and edge detector for the GPIO block.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   in_port     : asynchronous external inputs (WIDTH bits)
//   sync_in     : in_port after SYNC_STAGES flops
//   edge_pulse  : one-cycle pulse per bit on the selected edge, held off
//                 until the synchronizer and prev register hold real data
module pio_sync_edge
  import pio_gpio_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_raw;
  logic [2:0]       prime_cnt;
  logic             primed;

  // primed rises SYNC_STAGES+1 clocks after reset release, once prev holds a
  // genuinely sampled value; an input that is static high would otherwise
  // look like a rising edge while the pipeline fills from its reset zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev      <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_q[SYNC_STAGES-1];
      if (!primed) begin
        if (prime_cnt == 3'(SYNC_STAGES)) primed <= 1'b1;
        else prime_cnt <= prime_cnt + 3'd1;
      end
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev;
  assign fall    = ~sync_in & prev;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_raw = fall;
      EDGE_ANY:  edge_raw = rise | fall;
      default:   edge_raw = rise;
    endcase
  end

  assign edge_pulse = primed ? edge_raw : '0;

endmodule

// File: rtl/pio_gpio_irq.sv
// Memory-mapped GPIO port with per-bit direction, set/clear strobes and
// sticky edge capture driving a level interrupt.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   address, chipselect : register select / slave select
//   write_n, writedata  : active-low write strobe, 32-bit write data
//   readdata            : combinational read data, zero-extended
//   in_port             : asynchronous external inputs
//   out_port, oe_port   : output data register, per-bit output enable
//   irq                 : registered |(capture & mask)
module pio_gpio_irq
  import pio_gpio_pkg::*;
#(
  parameter int          WIDTH       = 14,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_val;
  logic             wr;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .sync_in   (sync_in),
    .edge_pulse(edge_pulse)
  );

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign cap_clr      = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  // Clear is applied before the OR so a same-cycle edge wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      oe       <= '0;
      mask     <= '0;
      capture  <= '0;
      irq      <= 1'b0;
    end else begin
      capture <= (capture & ~cap_clr) | edge_pulse;
      irq     <= |(capture & mask);
      if (wr) begin
        case (address)
          ADDR_DATA:    data_out <= wdata;
          ADDR_DIR:     oe       <= wdata;
          ADDR_IRQMASK: mask     <= wdata;
          ADDR_OUTSET:  data_out <= data_out | wdata;
          ADDR_OUTCLR:  data_out <= data_out & ~wdata;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (oe & data_out) | (~oe & sync_in);
      ADDR_DIR:     rd_val = oe;
      ADDR_IRQMASK: rd_val = mask;
      ADDR_EDGECAP: rd_val = capture;
      default:      rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_out;
  assign oe_port  = oe;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Self-checking bench for pio_gpio_irq (WIDTH=14, RESET_VALUE=0x2A5,
// rising-edge capture, 2 synchronizer stages). A reference model tracks the
// register file and derives sync_in/prev from a history of sampled inputs.
module tb_pio_gpio_irq;

  localparam int          W  = 14;
  localparam int          S  = 2;
  localparam int          ET = 0;
  localparam logic [13:0] RV = 14'h2A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [13:0] in_port;
  logic [13:0] out_port;
  logic [13:0] oe_port;
  logic        irq;

  int ncomp = 0;
  int nfail = 0;

  logic [13:0] m_dout, m_oe, m_mask, m_cap;
  logic        m_irq;
  logic [13:0] samp[$];
  int          ncyc;
  logic [13:0] cur_in;

  pio_gpio_irq #(
    .WIDTH      (W),
    .RESET_VALUE(32'h2A5),
    .EDGE_TYPE  (ET),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .oe_port   (oe_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_dout = RV;
    m_oe   = '0;
    m_mask = '0;
    m_cap  = '0;
    m_irq  = 1'b0;
    samp.delete();
    ncyc   = 0;
  endtask

  // sync_in is the input sampled S clocks ago, prev the one before that.
  function automatic logic [13:0] sync_now();
    if (samp.size() >= S) return samp[S-1];
    return '0;
  endfunction

  function automatic logic [13:0] prev_now();
    if (samp.size() >= S + 1) return samp[S];
    return '0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    logic [13:0] v;
    case (a)
      3'd0:    v = (m_oe & m_dout) | (~m_oe & sync_now());
      3'd1:    v = m_oe;
      3'd2:    v = m_mask;
      3'd3:    v = m_cap;
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_step(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] wd, input logic [13:0] inp);
    logic [13:0] s, p, ed, clr, d;
    logic        nirq;
    if (reset) return;
    s = sync_now();
    p = prev_now();
    case (ET)
      1:       ed = ~s & p;
      2:       ed = s ^ p;
      default: ed = s & ~p;
    endcase
    if (ncyc < S + 1) ed = '0;
    d    = wd[13:0];
    clr  = (cs && !wn && a == 3'd3) ? d : 14'h0;
    nirq = |(m_cap & m_mask);
    m_cap = (m_cap & ~clr) | ed;
    if (cs && !wn) begin
      case (a)
        3'd0: m_dout = d;
        3'd1: m_oe   = d;
        3'd2: m_mask = d;
        3'd4: m_dout = m_dout | d;
        3'd5: m_dout = m_dout & ~d;
        default: ;
      endcase
    end
    m_irq = nirq;
    samp.push_front(inp);
    if (samp.size() > S + 1) void'(samp.pop_back());
    ncyc++;
  endtask

  // One clock: drive at the falling edge, compare just after, advance model.
  task automatic cyc(input logic cs, input logic wn, input logic [2:0] a,
                     input logic [31:0] wd, input logic [13:0] inp);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = inp;
    if (reset) model_reset();
    #1;
    check("readdata", readdata, exp_rd(a));
    check("out_port", 32'(out_port), 32'(m_dout));
    check("oe_port", 32'(oe_port), 32'(m_oe));
    check("irq", 32'(irq), 32'(m_irq));
    model_step(cs, wn, a, wd, inp);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, cur_in);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 3'd3, 32'h0, cur_in);
  endtask

  task automatic peek(input logic [2:0] a, input string tag, input logic [31:0] expv);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, expv);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0; cur_in = '0;
    model_reset();
    @(negedge clk);

    // Reset state; oe is 0 so every data bit reads the (zero) synchronized input.
    for (int a = 0; a < 8; a++) cyc(1'b1, 1'b1, 3'(a), 32'h0, cur_in);
    check("rst_out_port", 32'(out_port), 32'h2A5);
    check("rst_oe_port", 32'(oe_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 6; a++) peek(3'(a), "rst_read", 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Data, set and clear strobes.
    wr(3'd0, 32'h00F0);
    wr(3'd4, 32'h000F);
    wr(3'd5, 32'h0030);
    check("outset_outclr", 32'(out_port), 32'h00CF);
    wr(3'd1, 32'h3FFF);
    wr(3'd0, 32'hFFFF_FFFF);
    peek(3'd0, "data_trunc", 32'h0000_3FFF);
    peek(3'd4, "outset_read0", 32'h0);
    peek(3'd5, "outclr_read0", 32'h0);

    // Mixed direction read-back.
    wr(3'd1, 32'h00FF);
    wr(3'd0, 32'h0055);
    cur_in = 14'h3F00;
    idle(3);
    peek(3'd0, "mixed_read", 32'h3F55);

    // Single rising edge: capture after S+1 clocks, irq one later, clear.
    wr(3'd2, 32'h0001);
    wr(3'd3, 32'h3FFF);
    cur_in = 14'h3F01;
    idle(2);
    peek(3'd3, "cap_early", 32'h0);
    idle(1);
    peek(3'd3, "cap_latency", 32'h1);
    check("irq_lag", 32'(irq), 32'h0);
    idle(1);
    check("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h0001);
    peek(3'd3, "cap_cleared", 32'h0);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Static-high input across reset release must not capture.
    cur_in = 14'h3FFF;
    reset  = 1'b1;
    idle(3);
    reset  = 1'b0;
    idle(6);
    peek(3'd3, "static_high", 32'h0);

    // Edge and clear-write on the same bit in the same cycle: set wins.
    cur_in = 14'h3FDF;
    idle(4);
    peek(3'd3, "fall_ignored", 32'h0);
    cur_in = 14'h3FFF;
    idle(2);
    wr(3'd3, 32'h0020);
    peek(3'd3, "set_wins", 32'h20);

    // Asynchronous reset discards captures and irq without a clock edge.
    wr(3'd2, 32'h0003);
    wr(3'd3, 32'h3FFF);
    cur_in = 14'h3FFC;
    idle(3);
    cur_in = 14'h3FFF;
    idle(4);
    peek(3'd3, "cap_pre_rst", 32'h3);
    check("irq_pre_rst", 32'(irq), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("async_cap", readdata, 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    check("async_out", 32'(out_port), 32'h2A5);
    model_reset();
    @(negedge clk);
    idle(2);
    reset = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [13:0] flip;
      flip   = 14'($urandom) & 14'($urandom) & 14'($urandom);
      cur_in = cur_in ^ flip;
      if (i == 200) reset = 1'b1;
      if (i == 203) reset = 1'b0;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), $urandom, cur_in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
